// File: rtl/fp_normalizer.sv
// Normalizes a raw half-precision sum using the upstream leading-one index: 2-stage pipeline,
// result 2 cycles after acceptance, valid/ready backpressure that stalls both stages without loss.
module fp_normalizer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [4:0]  in_exp,
   input  logic [11:0] in_mant,
   input  logic [3:0]  in_lead_pos,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic        out_ovf,
   output logic        out_unf,
   output logic        out_zero
);

   logic s1_valid;
   logic s2_valid;
   logic s1_adv;
   logic s2_adv;

   // Stage 1 state; the carry bit is never needed past stage 1, so only [10:0] is kept
   logic               s1_sign;
   logic [10:0]        s1_mant;
   logic               s1_shr;
   logic [3:0]         s1_shamt;
   logic signed [6:0]  s1_exp;
   logic               s1_zero;

   logic               c_shr;
   logic [3:0]         c_shamt;
   logic signed [6:0]  c_exp;
   logic               c_zero;

   logic [9:0]         c_frac;
   logic [15:0]        c_result;
   logic               c_ovf;
   logic               c_unf;
   logic               c_zero2;

   assign in_ready  = !s1_valid || !s2_valid || out_ready;
   assign s1_adv    = in_valid && in_ready;
   assign s2_adv    = s1_valid && (!s2_valid || out_ready);
   assign out_valid = s2_valid;

   // Exponent kept 7-bit signed so in_exp+1 and in_exp-10 never wrap
   always_comb begin
      c_shr   = 1'b0;
      c_shamt = 4'd0;
      c_exp   = $signed({2'b00, in_exp});
      c_zero  = (in_mant == 12'h000) || (in_lead_pos > 4'd11);
      if (in_lead_pos == 4'd11) begin
         c_shr = 1'b1;
         c_exp = $signed({2'b00, in_exp}) + 7'sd1;
      end else if (in_lead_pos < 4'd10) begin
         c_shamt = 4'd10 - in_lead_pos;
         c_exp   = $signed({2'b00, in_exp}) - $signed({3'b000, c_shamt});
      end
   end

   always_comb begin
      c_frac   = s1_shr ? s1_mant[10:1] : (s1_mant[9:0] << s1_shamt);
      c_result = {s1_sign, s1_exp[4:0], c_frac};
      c_ovf    = 1'b0;
      c_unf    = 1'b0;
      c_zero2  = 1'b0;
      if (s1_zero) begin
         c_result = {s1_sign, 15'h0000};
         c_zero2  = 1'b1;
      end else if (s1_exp >= 7'sd31) begin
         c_result = {s1_sign, 5'h1F, 10'h000};
         c_ovf    = 1'b1;
      end else if (s1_exp <= 7'sd0) begin
         c_result = {s1_sign, 15'h0000};
         c_unf    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         out_result <= 16'h0000;
         out_ovf    <= 1'b0;
         out_unf    <= 1'b0;
         out_zero   <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= 1'b1;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
         if (s2_adv) begin
            s2_valid   <= 1'b1;
            out_result <= c_result;
            out_ovf    <= c_ovf;
            out_unf    <= c_unf;
            out_zero   <= c_zero2;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s1_adv) begin
         s1_sign  <= in_sign;
         s1_mant  <= in_mant[10:0];
         s1_shr   <= c_shr;
         s1_shamt <= c_shamt;
         s1_exp   <= c_exp;
         s1_zero  <= c_zero;
      end
   end

endmodule
